// File: rtl/apb4_master_mux_if.sv
// Request/response channel from the bridge plus the APB bus towards the slaves.
// The master modport is the mux side; the slave modport is the bridge/peripheral side.
interface apb4_master_mux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             req_valid;
  logic                             req_ready;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic                             req_write;
  logic [DATA_WIDTH-1:0]            req_wdata;
  logic [DATA_WIDTH/8-1:0]          req_strb;
  logic [2:0]                       req_prot;

  logic                             rsp_valid;
  logic [1:0]                       rsp_code;
  logic [DATA_WIDTH-1:0]            rsp_rdata;

  logic [NUM_SLAVES-1:0]            psel;
  logic                             penable;
  logic                             pwrite;
  logic [ADDR_WIDTH-1:0]            paddr;
  logic [DATA_WIDTH-1:0]            pwdata;
  logic [DATA_WIDTH/8-1:0]          pstrb;
  logic [2:0]                       pprot;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES-1:0]            pslverr;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_code, rsp_rdata,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_code, rsp_rdata,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb4_master_mux.sv
// APB4 master: takes single transfers from the bridge, decodes the slave from an
// address field, runs SETUP/ACCESS and returns a one-cycle status response.
module apb4_master_mux #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input logic                pclk,
  input logic                preset,
  apb4_master_mux_if.master  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W:0]   NUM_LIMIT  = (IDX_W+1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             TIMEOUT_EN = (TIMEOUT > 0);

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_DECERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [1:0]              rsp_code_q, rsp_code_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0]        idx;
  logic                    idx_ok;
  logic [NUM_SLAVES-1:0]   psel_dec;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  assign idx    = bus.req_addr[SEL_LSB +: IDX_W];
  assign idx_ok = ({1'b0, idx} < NUM_LIMIT);

  always_comb begin
    psel_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) psel_dec[i] = 1'b1;
    end
  end

  // The registered one-hot psel doubles as the response mux select, so only the
  // addressed slave's pready/pslverr/prdata can ever reach the response.
  assign sel_ready = |(bus.pready & psel_q);
  assign sel_err   = |(bus.pslverr & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) sel_rdata |= bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (idx_ok) begin
            paddr_d   = bus.req_addr;
            pwrite_d  = bus.req_write;
            pprot_d   = bus.req_prot;
            pwdata_d  = bus.req_write ? bus.req_wdata : '0;
            pstrb_d   = bus.req_write ? bus.req_strb  : '0;
            psel_d    = psel_dec;
            penable_d = 1'b0;
            state_d   = SETUP;
          end else begin
            state_d   = DERR;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // pready is tested first so a ready slave on the last allowed cycle still completes.
        if (sel_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = sel_err ? RSP_SLVERR : RSP_OK;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
          state_d     = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DERR: begin
        rsp_valid_d = 1'b1;
        rsp_code_d  = RSP_DECERR;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= '0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_code  = rsp_code_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;

endmodule

// File: doc/apb4_master_mux.md
Name: apb4_master_mux

Overview:
- Parametrised APB4 master. Accepts single transfers from the bridge over a valid/ready request channel and drives one of NUM_SLAVES APB slaves.
- Selects the slave by address decode and muxes the selected slave's pready/pslverr/prdata.
- Returns a one-cycle response carrying a status code: OK, slave error, decode error or timeout.
- Sits between the AHB/AXI-to-APB bridge front end and the peripheral slaves.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
NUM_SLAVES, 4, number of APB slaves (1..16)
SEL_LSB, 12, lowest address bit of the slave index field
TIMEOUT, 16, ACCESS wait cycles before abort; 0 disables timeout

Ports:
pclk  in  1  clock
preset  in  1  synchronous reset, active-high
req_valid  in  1  bridge request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  ADDR_WIDTH  transfer address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte strobes
req_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
rsp_code  out  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
rsp_rdata  out  DATA_WIDTH  read data
psel  out  NUM_SLAVES  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
pready  in  NUM_SLAVES  per-slave ready
pslverr  in  NUM_SLAVES  per-slave error
prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (preset=1 at a pclk edge): state IDLE. All outputs 0, except req_ready=1.
- Reset mid-transfer aborts immediately: psel=0, no rsp_valid is generated, and no transfer is resumed.
- States: IDLE, SETUP, ACCESS, DERR.
- req_ready is combinational: it is 1 exactly when state=IDLE.
- Slave index idx = req_addr[SEL_LSB +: clog2(NUM_SLAVES)]; use width 1 when NUM_SLAVES=1.
- IDLE, on accept with idx < NUM_SLAVES:
  - Register paddr=req_addr, pwrite=req_write and pprot=req_prot.
  - pwdata=req_wdata and pstrb=req_strb for writes; both 0 for reads.
  - psel[idx]=1, penable=0. Go to SETUP.
- IDLE, on accept with idx >= NUM_SLAVES: psel stays 0. Go to DERR.
- SETUP: lasts exactly 1 cycle. Register penable=1, then go to ACCESS. The wait counter clears to 0.
- ACCESS: all APB outputs hold stable. Only the selected slave's pready/pslverr/prdata are observed.
  - pready[idx]=1: register psel=0, penable=0, rsp_valid=1. rsp_code=01 if pslverr[idx] else 00. rsp_rdata=prdata slice for reads, 0 for writes. Go to IDLE.
  - pready[idx]=0 with TIMEOUT>0 and counter=TIMEOUT-1: abort. Register psel=0, penable=0, rsp_valid=1, rsp_code=11, rsp_rdata=0. Go to IDLE.
  - Otherwise the counter increments.
- DERR: register rsp_valid=1, rsp_code=10, rsp_rdata=0. Go to IDLE.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_code and rsp_rdata hold until the next response.
- Throughput:
  - Zero-wait transfer: accept at edge 0, SETUP visible in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - req_ready=1 in the rsp_valid cycle, so back-to-back transfers take 3 cycles each.
- paddr, pwrite, pwdata, pstrb and pprot hold their last values after a transfer. penable=1 only when some psel bit is 1.
- Simultaneous pready with the timeout-boundary cycle: pready wins and the transfer completes normally.
- TIMEOUT=1 aborts after the first ACCESS cycle without pready.

Test Plan:
- Reset, then write addr 0x0000_1004, data 0xDEADBEEF, strb 0xF, slave 1 zero-wait -> psel=0010 in cycle 1, penable=1 in cycle 2, rsp_valid in cycle 3 with rsp_code=00 and rsp_rdata=0.
- Read addr 0x0000_3010, slave 3 with pready low for 3 ACCESS cycles, prdata=0x12345678 -> pstrb=0, ACCESS lasts 4 cycles, rsp_code=00, rsp_rdata=0x12345678.
- Write to slave 2 with pslverr=1 on the pready cycle -> rsp_code=01, psel and penable drop the next cycle.
- NUM_SLAVES=3, addr 0x0000_3000 -> no psel asserted, rsp_valid one cycle after accept with rsp_code=10.
- TIMEOUT=16, slave 0 never ready -> exactly 16 ACCESS cycles, then rsp_code=11, rsp_rdata=0, psel=0.
- preset asserted during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=1. A new read after reset completes normally.
